// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control sequencer with writable control store, opcode dispatch table and return stack (optional MICRO_SEQ_ERR_EN)
module micro_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int SIG_W       = 5,
    parameter int OPCODE_W    = 5,
    parameter int CSEL_W      = 2,
    parameter int STACK_DEPTH = 4,
    parameter int W           = ADDR_W + 3 + 1 + CSEL_W + SIG_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [2**CSEL_W-1:0] flags,
    input  logic                 load_en,
    input  logic                 load_sel,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [W-1:0]         load_data,
    output logic [SIG_W-1:0]     signals,
    output logic [ADDR_W-1:0]    upc,
    output logic                 halted,
    output logic                 err
);
    localparam logic [2:0] OP_DISP = 3'b001;
    localparam logic [2:0] OP_BR   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;
    localparam int IDX_W = $clog2(STACK_DEPTH);
`ifdef MICRO_SEQ_ERR_EN
    localparam int SP_W = IDX_W + 1;
`else
    localparam int SP_W = IDX_W;
`endif

    logic [W-1:0]           store [2**ADDR_W];
    logic [ADDR_W-1:0]      tbl_tgt [2**OPCODE_W];
    logic [2**OPCODE_W-1:0] tbl_vld;
    logic [ADDR_W-1:0]      stack [STACK_DEPTH];
    logic [W-1:0]           current;
    logic [SP_W-1:0]        sp, sp_dec;
    logic [ADDR_W-1:0]      next_addr, upc_inc, chosen;
    logic [2:0]             seq_op;
    logic [CSEL_W-1:0]      cond_sel;
    logic                   cond_pol, push, pop;
`ifdef MICRO_SEQ_ERR_EN
    logic                   fault;
`endif

    assign next_addr = current[W-1 -: ADDR_W];
    assign seq_op    = current[SIG_W+CSEL_W+1 +: 3];
    assign cond_pol  = current[SIG_W+CSEL_W];
    assign cond_sel  = current[SIG_W +: CSEL_W];
    assign signals   = current[SIG_W-1:0];
    assign upc_inc   = upc + 1'b1;
    assign sp_dec    = sp - 1'b1;

    // next-address selection plus the stack and fault side effects of the current microinstruction
    always_comb begin
        chosen = next_addr;
        push   = 1'b0;
        pop    = 1'b0;
`ifdef MICRO_SEQ_ERR_EN
        fault  = 1'b0;
`endif
        case (seq_op)
            OP_DISP: begin
                chosen = tbl_vld[opcode] ? tbl_tgt[opcode] : '0;
`ifdef MICRO_SEQ_ERR_EN
                fault  = !tbl_vld[opcode];
`endif
            end
            OP_BR:   chosen = (flags[cond_sel] == cond_pol) ? next_addr : upc_inc;
            OP_CALL: begin
`ifdef MICRO_SEQ_ERR_EN
                push  = sp != SP_W'(STACK_DEPTH);
                fault = sp == SP_W'(STACK_DEPTH);
`else
                push  = 1'b1;
`endif
            end
            OP_RET:  begin
`ifdef MICRO_SEQ_ERR_EN
                pop    = sp != '0;
                fault  = sp == '0;
                chosen = (sp != '0) ? stack[sp_dec[IDX_W-1:0]] : '0;
`else
                pop    = 1'b1;
                chosen = stack[sp_dec[IDX_W-1:0]];
`endif
            end
            OP_HALT: chosen = upc;
            default: ;
        endcase
    end

    // sequencing state: async reset, cleared while loading, otherwise advances unless stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current <= '0;
            upc     <= '0;
            sp      <= '0;
            halted  <= 1'b0;
        end else if (load_en) begin
            current <= '0;
            upc     <= '0;
            sp      <= '0;
            halted  <= 1'b0;
        end else if (!stall) begin
            current <= store[chosen];
            upc     <= chosen;
            halted  <= halted | (seq_op == OP_HALT);
            if (push)
                sp <= sp + 1'b1;
            else if (pop)
                sp <= sp_dec;
        end
    end

    // return stack storage, written on every accepted push; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && !load_en && !stall && push)
            stack[sp[IDX_W-1:0]] <= upc_inc;
    end

    // microcode and dispatch-target writes; contents survive reset
    always_ff @(posedge clk) begin
        if (load_en && !load_sel)
            store[load_addr] <= load_data;
        if (load_en && load_sel)
            tbl_tgt[load_addr[OPCODE_W-1:0]] <= load_data[ADDR_W-1:0];
    end

    // dispatch entry valid bits, cleared by reset so stale targets are never used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tbl_vld <= '0;
        else if (load_en && load_sel)
            tbl_vld[load_addr[OPCODE_W-1:0]] <= load_data[ADDR_W];
    end

`ifdef MICRO_SEQ_ERR_EN
    // sticky sequencing fault flag, cleared by reset or a microcode load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (load_en)
            err <= 1'b0;
        else if (!stall && fault)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: vector table, hand sequences and randomized reference-model comparison for micro_sequencer
module tb_micro_sequencer;
    localparam int AW = 5, SW = 5, OW = 5, CW = 2, SD = 4;
    localparam int W = AW + 3 + 1 + CW + SW;
    localparam int OP_JUMP = 0, OP_DISP = 1, OP_BR = 2, OP_CALL = 3, OP_RET = 4, OP_HALT = 5;
`ifdef MICRO_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, stall = 1'b0, load_en = 1'b0, load_sel = 1'b0;
    logic [OW-1:0] opcode = '0;
    logic [2**CW-1:0] flags = '0;
    logic [AW-1:0] load_addr = '0;
    logic [W-1:0]  load_data = '0;
    logic [SW-1:0] signals;
    logic [AW-1:0] upc;
    logic          halted, err;
    int            n_cmp = 0, n_fail = 0;

    typedef struct { bit stall; logic [AW-1:0] upc; logic [SW-1:0] sig; } vec_t;
    vec_t vt [9];

    micro_sequencer #(.ADDR_W(AW), .SIG_W(SW), .OPCODE_W(OW), .CSEL_W(CW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .opcode(opcode), .flags(flags),
        .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
        .signals(signals), .upc(upc), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    // reference model: architectural state kept as plain integers and arrays
    logic [W-1:0] m_store [2**AW];
    int           m_tgt [2**OW];
    bit           m_vld [2**OW];
    int           m_stk [SD];
    logic [W-1:0] m_cur = '0;
    int           m_pc = 0, m_sp = 0;
    bit           m_halt = 1'b0, m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin : ref_model
        int op, na, nxt, sel;
        bit pol;
        if (!rst_n) begin
            m_cur = '0; m_pc = 0; m_sp = 0; m_halt = 1'b0; m_err = 1'b0;
            foreach (m_vld[i]) m_vld[i] = 1'b0;
        end else if (load_en) begin
            if (load_sel) begin
                m_vld[load_addr[OW-1:0]] = load_data[AW];
                m_tgt[load_addr[OW-1:0]] = int'(load_data[AW-1:0]);
            end else
                m_store[load_addr] = load_data;
            m_cur = '0; m_pc = 0; m_sp = 0; m_halt = 1'b0; m_err = 1'b0;
        end else if (!stall) begin
            na  = int'(m_cur[W-1 -: AW]);
            op  = int'(m_cur[W-AW-1 -: 3]);
            pol = m_cur[SW+CW];
            sel = int'(m_cur[SW +: CW]);
            nxt = na;
            if (op == OP_DISP) begin
                nxt = m_vld[opcode] ? m_tgt[opcode] : 0;
                if (!m_vld[opcode] && ERR_EN) m_err = 1'b1;
            end else if (op == OP_BR) begin
                if (flags[sel] != pol) nxt = (m_pc + 1) % (1 << AW);
            end else if (op == OP_CALL) begin
                if (ERR_EN && m_sp == SD) m_err = 1'b1;
                else begin
                    m_stk[m_sp % SD] = (m_pc + 1) % (1 << AW);
                    m_sp = ERR_EN ? m_sp + 1 : (m_sp + 1) % SD;
                end
            end else if (op == OP_RET) begin
                if (ERR_EN && m_sp == 0) begin
                    nxt = 0;
                    m_err = 1'b1;
                end else begin
                    m_sp = (m_sp + SD - 1) % SD;
                    nxt = m_stk[m_sp];
                end
            end else if (op == OP_HALT) begin
                nxt = m_pc;
                m_halt = 1'b1;
            end
            m_pc = nxt;
            m_cur = m_store[nxt];
        end
    end

    function automatic logic [W-1:0] mk(int na, int op, int pol, int sel, int sig);
        return {AW'(na), 3'(op), 1'(pol), CW'(sel), SW'(sig)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ld(bit sel, int addr, logic [W-1:0] d);
        load_en = 1'b1; load_sel = sel; load_addr = AW'(addr); load_data = d;
        cyc();
    endtask

    task automatic step_chk(string tag, int exp_upc, int exp_sig, bit exp_halt);
        cyc();
        check({tag, "_upc"}, 32'(upc), 32'(exp_upc));
        check({tag, "_sig"}, 32'(signals), 32'(exp_sig));
        check({tag, "_halted"}, 32'(halted), 32'(exp_halt));
    endtask

    int call_err [12] = '{0, 10, 12, 14, 16, 18, 20, 17, 15, 13, 11, 0};
    int call_wrap [12] = '{0, 10, 12, 14, 16, 18, 20, 19, 17, 15, 13, 19};

    initial begin
        vt = '{'{1'b0, 5'd0, 5'h01}, '{1'b0, 5'd1, 5'h02}, '{1'b0, 5'd0, 5'h01},
               '{1'b1, 5'd0, 5'h01}, '{1'b1, 5'd0, 5'h01}, '{1'b1, 5'd0, 5'h01},
               '{1'b0, 5'd1, 5'h02}, '{1'b0, 5'd0, 5'h01}, '{1'b0, 5'd1, 5'h02}};

        #2 rst_n = 1'b0;
        #1;
        check("rst_upc", 32'(upc), 32'd0);
        check("rst_sig", 32'(signals), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // alternating JUMP pair, with a 3-cycle stall in the middle
        ld(0, 0, mk(1, OP_JUMP, 0, 0, 5'h01));
        ld(0, 1, mk(0, OP_JUMP, 0, 0, 5'h02));
        load_en = 1'b0;
        foreach (vt[i]) begin
            stall = vt[i].stall;
            cyc();
            check($sformatf("vec%0d_upc", i), 32'(upc), 32'(vt[i].upc));
            check($sformatf("vec%0d_sig", i), 32'(signals), 32'(vt[i].sig));
        end
        stall = 1'b0;

        // dispatch: valid entry, then an invalid one
        ld(0, 0, mk(0, OP_DISP, 0, 0, 5'h03));
        ld(0, 2, mk(0, OP_JUMP, 0, 0, 5'h04));
        ld(1, 7, W'((1 << AW) | 2));
        load_en = 1'b0;
        opcode = 5'b00111;
        step_chk("disp0", 0, 5'h03, 1'b0);
        step_chk("disp1", 2, 5'h04, 1'b0);
        step_chk("disp2", 0, 5'h03, 1'b0);
        check("disp_err_before", 32'(err), 32'd0);
        opcode = 5'b01111;
        step_chk("disp_inv", 0, 5'h03, 1'b0);
        check("disp_inv_err", 32'(err), 32'(ERR_EN));

        // flag-conditional branch taken and not taken
        ld(0, 0, mk(3, OP_JUMP, 0, 0, 5'h00));
        ld(0, 3, mk(9, OP_BR, 1, 1, 5'h05));
        ld(0, 9, mk(0, OP_JUMP, 0, 0, 5'h09));
        ld(0, 4, mk(0, OP_JUMP, 0, 0, 5'h0A));
        load_en = 1'b0;
        flags = 4'b0010;
        step_chk("br0", 0, 5'h00, 1'b0);
        step_chk("br1", 3, 5'h05, 1'b0);
        step_chk("br_taken", 9, 5'h09, 1'b0);
        step_chk("br3", 0, 5'h00, 1'b0);
        flags = 4'b0000;
        step_chk("br4", 3, 5'h05, 1'b0);
        step_chk("br_fall", 4, 5'h0A, 1'b0);
        check("br_err", 32'(err), 32'd0);

        // five nested CALLs then five RETs
        ld(0, 0, mk(10, OP_JUMP, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            ld(0, 10 + 2 * k, mk(12 + 2 * k, OP_CALL, 0, 0, k));
            ld(0, 11 + 2 * k, mk(0, OP_RET, 0, 0, 16 + k));
        end
        ld(0, 20, mk(0, OP_RET, 0, 0, 5'h1F));
        load_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check($sformatf("call%0d_upc", i), 32'(upc), 32'(ERR_EN ? call_err[i] : call_wrap[i]));
            check($sformatf("call%0d_err", i), 32'(err), 32'(ERR_EN && i >= 6));
        end

        // halt, then asynchronous reset between edges
        ld(0, 0, mk(6, OP_JUMP, 0, 0, 5'h11));
        ld(0, 6, mk(0, OP_HALT, 0, 0, 5'h06));
        load_en = 1'b0;
        step_chk("halt0", 0, 5'h11, 1'b0);
        step_chk("halt1", 6, 5'h06, 1'b0);
        step_chk("halt2", 6, 5'h06, 1'b1);
        step_chk("halt3", 6, 5'h06, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_upc", 32'(upc), 32'd0);
        check("arst_sig", 32'(signals), 32'd0);
        check("arst_halted", 32'(halted), 32'd0);
        #1 rst_n = 1'b1;
        step_chk("post_rst0", 0, 5'h11, 1'b0);
        step_chk("post_rst1", 6, 5'h06, 1'b0);

        // randomized microcode against the reference model
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < (1 << AW); a++) ld(0, a, W'($urandom));
            for (int a = 0; a < (1 << OW); a++) ld(1, a, W'($urandom));
            load_en = 1'b0;
            for (int c = 0; c < 150; c++) begin
                stall = ($urandom_range(0, 4) == 0);
                opcode = OW'($urandom);
                flags = (2**CW)'($urandom);
                load_en = ($urandom_range(0, 24) == 0);
                load_sel = 1'($urandom);
                load_addr = AW'($urandom);
                load_data = W'($urandom);
                if ($urandom_range(0, 99) == 0) begin
                    #1 rst_n = 1'b0;
                    #1 rst_n = 1'b1;
                end
                cyc();
                check("rnd_upc", 32'(upc), 32'(m_pc));
                check("rnd_sig", 32'(signals), 32'(m_cur[SW-1:0]));
                check("rnd_halted", 32'(halted), 32'(m_halt));
                check("rnd_err", 32'(err), 32'(m_err));
            end
            load_en = 1'b0;
            stall = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
